// File: rtl/hni_rxrsp_link_if.sv
// Signal bundle between the CHI RSP receive pins, the link front end and hni_rxrsp.
// The slave modport is the link front end; master is the surrounding environment.
interface hni_rxrsp_link_if #(
  parameter int FLIT_W = 65
);
  logic              RXLINKACTIVEREQ;
  logic              RXLINKACTIVEACK;
  logic              RXRSPFLITPEND;
  logic              RXRSPFLITV;
  logic [FLIT_W-1:0] RXRSPFLIT;
  logic              RXRSPLCRDV;
  logic              rxrspflitpend;
  logic              rxrspflitv;
  logic [FLIT_W-1:0] rxrspflit;
  logic              rxrsp_lcrdv;
  logic              rxlink_run;
  logic              rxrsp_crd_err;

  modport master (
    output RXLINKACTIVEREQ, RXRSPFLITPEND, RXRSPFLITV, RXRSPFLIT, rxrsp_lcrdv,
    input  RXLINKACTIVEACK, RXRSPLCRDV, rxrspflitpend, rxrspflitv, rxrspflit,
           rxlink_run, rxrsp_crd_err
  );

  modport slave (
    input  RXLINKACTIVEREQ, RXRSPFLITPEND, RXRSPFLITV, RXRSPFLIT, rxrsp_lcrdv,
    output RXLINKACTIVEACK, RXRSPLCRDV, rxrspflitpend, rxrspflitv, rxrspflit,
           rxlink_run, rxrsp_crd_err
  );
endinterface

// File: rtl/hni_rxrsp_link.sv
// RX-RSP link-layer front end: link activation FSM, flit registering with LCrdReturn
// absorption, and pending/outstanding credit tracking across deactivation.
module hni_rxrsp_link #(
  parameter int CRD_MAX = 15,
  parameter int CNT_W   = 4,
  parameter int FLIT_W  = 65,
  parameter int OPC_LSB = 38,
  parameter int OPC_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  hni_rxrsp_link_if.slave   lnk
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_ACT   = 2'b01,
    ST_RUN   = 2'b10,
    ST_DEACT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CRD_MAX_C = CNT_W'(CRD_MAX);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic              lcrdv_q;
  logic              flitv_q;
  logic [FLIT_W-1:0] flit_q;
  logic              flitpend_q;
  logic              err_q;

  logic accept;
  logic is_lcrd;
  logic fwd;
  logic issue;
  logic stop_flit;
  logic underflow;
  logic overflow;

  assign accept    = lnk.RXRSPFLITV && (state_q != ST_STOP);
  assign is_lcrd   = (lnk.RXRSPFLIT[OPC_LSB +: OPC_W] == '0);
  assign fwd       = accept && !is_lcrd;
  assign issue     = (state_q == ST_RUN) && ((pend_q != '0) || lnk.rxrsp_lcrdv);
  assign stop_flit = lnk.RXRSPFLITV && (state_q == ST_STOP);
  // A credit issued this cycle covers a flit arriving with out_cnt at zero.
  assign underflow = accept && (out_q == '0) && !issue;
  assign overflow  = lnk.rxrsp_lcrdv && !issue && (pend_q == CRD_MAX_C);

  always_comb begin
    pend_d = pend_q;
    if (lnk.rxrsp_lcrdv && !issue) begin
      if (pend_q != CRD_MAX_C) begin
        pend_d = pend_q + ONE_C;
      end
    end else if (!lnk.rxrsp_lcrdv && issue) begin
      pend_d = pend_q - ONE_C;
    end
  end

  always_comb begin
    out_d = out_q;
    if (issue && !accept) begin
      if (out_q != CRD_MAX_C) begin
        out_d = out_q + ONE_C;
      end
    end else if (accept && !issue) begin
      if (out_q != '0) begin
        out_d = out_q - ONE_C;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (lnk.RXLINKACTIVEREQ) state_d = ST_ACT;
      ST_ACT:   state_d = lnk.RXLINKACTIVEREQ ? ST_RUN : ST_DEACT;
      ST_RUN:   if (!lnk.RXLINKACTIVEREQ) state_d = ST_DEACT;
      // Wait until every issued credit has come back before returning to STOP.
      ST_DEACT: if ((out_q == '0) && !lnk.RXRSPFLITV) state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOP;
      pend_q     <= '0;
      out_q      <= '0;
      lcrdv_q    <= 1'b0;
      flitv_q    <= 1'b0;
      flit_q     <= '0;
      flitpend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      lcrdv_q    <= issue;
      flitv_q    <= fwd;
      flit_q     <= fwd ? lnk.RXRSPFLIT : '0;
      flitpend_q <= lnk.RXRSPFLITPEND;
      err_q      <= err_q | stop_flit | underflow | overflow;
    end
  end

  assign lnk.RXLINKACTIVEACK = (state_q != ST_STOP);
  assign lnk.rxlink_run      = (state_q == ST_RUN);
  assign lnk.RXRSPLCRDV      = lcrdv_q;
  assign lnk.rxrspflitv      = flitv_q;
  assign lnk.rxrspflit       = flit_q;
  assign lnk.rxrspflitpend   = flitpend_q;
  assign lnk.rxrsp_crd_err   = err_q;

endmodule

// File: tb/tb_hni_rxrsp_link.sv
// Scoreboard bench for hni_rxrsp_link: stimulus pushes expected flits/credit cycles,
// a negedge monitor pops and compares whenever the DUT presents a flit or a credit.
module tb_hni_rxrsp_link;
  localparam int FW = 65;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hni_rxrsp_link_if #(.FLIT_W(FW)) lnk ();

  hni_rxrsp_link #(
    .CRD_MAX(15), .CNT_W(4), .FLIT_W(FW), .OPC_LSB(38), .OPC_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lnk(lnk)
  );

  typedef struct {
    logic [FW-1:0] data;
    int            cyc;
  } exp_flit_t;

  exp_flit_t fq[$];
  int        cq[$];
  int        n_tests = 0;
  int        n_fail  = 0;

  function automatic void chk(string nm, logic [64:0] act, logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end else begin
      $display("[TB] ok %s at cycle %0d: %0h", nm, cyc, act);
    end
  endfunction

  function automatic logic [FW-1:0] mk_flit(int opc, logic [31:0] pay);
    logic [FW-1:0] f;
    f        = '0;
    f[31:0]  = pay;
    f[42:38] = opc[4:0];
    f[64:60] = pay[4:0];
    return f;
  endfunction

  task automatic goto(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every presented flit / credit pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (lnk.rxrspflitv) begin
        if (fq.size() == 0) begin
          chk("spurious_flit", lnk.rxrspflitv, 1'b0);
        end else begin
          exp_flit_t e;
          e = fq.pop_front();
          chk("flit_data", lnk.rxrspflit, e.data);
          chk("flit_cycle", cyc, e.cyc);
        end
      end
      if (lnk.RXRSPLCRDV) begin
        if (cq.size() == 0) begin
          chk("spurious_lcrdv", lnk.RXRSPLCRDV, 1'b0);
        end else begin
          chk("lcrdv_cycle", cyc, cq.pop_front());
        end
      end
    end
  end

  initial begin
    int r;
    lnk.RXLINKACTIVEREQ = 1'b0;
    lnk.RXRSPFLITPEND   = 1'b0;
    lnk.RXRSPFLITV      = 1'b0;
    lnk.RXRSPFLIT       = '0;
    lnk.rxrsp_lcrdv     = 1'b0;

    // Reset state
    goto(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", lnk.RXLINKACTIVEACK, 0);
    chk("rst_run", lnk.rxlink_run, 0);
    chk("rst_lcrdv", lnk.RXRSPLCRDV, 0);
    chk("rst_flitv", lnk.rxrspflitv, 0);
    chk("rst_flit", lnk.rxrspflit, 0);
    chk("rst_err", lnk.rxrsp_crd_err, 0);
    chk("rst_out_cnt", dut.out_q, 0);

    // Activation with 15 credits banked before RUN
    for (int i = 0; i < 15; i++) begin
      goto(4 + i);
      lnk.rxrsp_lcrdv = 1'b1;
    end
    goto(19);
    lnk.rxrsp_lcrdv = 1'b0;
    goto(20);
    r = 20;
    lnk.RXLINKACTIVEREQ = 1'b1;
    for (int i = 0; i < 15; i++) cq.push_back(r + 3 + i);
    goto(r + 1);
    @(negedge clk);
    chk("act_ack", lnk.RXLINKACTIVEACK, 1);
    chk("act_run", lnk.rxlink_run, 0);
    goto(r + 2);
    @(negedge clk);
    chk("run_entered", lnk.rxlink_run, 1);
    goto(r + 19);
    @(negedge clk);
    chk("act_out_cnt", dut.out_q, 15);
    chk("act_pend_cnt", dut.pend_q, 0);
    chk("act_credits_left", cq.size(), 0);

    // Steady RUN: 5 flits back-to-back, credits returned from cycle c+2
    for (int k = 0; k < 7; k++) begin
      goto(40 + k);
      lnk.RXRSPFLITV    = (k < 5);
      lnk.RXRSPFLIT     = (k < 5) ? mk_flit(k + 1, 32'h1234_0000 + 32'(k * 17)) : '0;
      lnk.RXRSPFLITPEND = (k == 0);
      lnk.rxrsp_lcrdv   = (k >= 2);
      if (k < 5) fq.push_back('{data: mk_flit(k + 1, 32'h1234_0000 + 32'(k * 17)), cyc: 41 + k});
      if (k >= 2) cq.push_back(41 + k);
      if (k == 1) begin
        @(negedge clk);
        chk("flitpend_reg", lnk.rxrspflitpend, 1);
      end
      if (k == 3) begin
        @(negedge clk);
        chk("simul_out_cnt", dut.out_q, 13);
      end
    end
    goto(47);
    lnk.RXRSPFLITV  = 1'b0;
    lnk.RXRSPFLIT   = '0;
    lnk.rxrsp_lcrdv = 1'b0;
    goto(50);
    @(negedge clk);
    chk("steady_out_cnt", dut.out_q, 15);
    chk("steady_err", lnk.rxrsp_crd_err, 0);

    // Deactivate: 15 LCrdReturn flits, the first in the cycle REQ falls
    goto(55);
    lnk.RXLINKACTIVEREQ = 1'b0;
    for (int k = 0; k < 15; k++) begin
      goto(55 + k);
      lnk.RXRSPFLITV = 1'b1;
      lnk.RXRSPFLIT  = mk_flit(0, 32'h00A0 + 32'(k));
      if (k == 1) begin
        @(negedge clk);
        chk("deact_run", lnk.rxlink_run, 0);
        chk("deact_ack", lnk.RXLINKACTIVEACK, 1);
      end
    end
    goto(70);
    lnk.RXRSPFLITV = 1'b0;
    lnk.RXRSPFLIT  = '0;
    @(negedge clk);
    chk("deact_ack_hold", lnk.RXLINKACTIVEACK, 1);
    chk("deact_out_cnt", dut.out_q, 0);
    goto(71);
    @(negedge clk);
    chk("stop_ack", lnk.RXLINKACTIVEACK, 0);
    chk("stop_err", lnk.rxrsp_crd_err, 0);

    // Re-activate with 15 credits reissued by hni_rxrsp
    for (int i = 0; i < 15; i++) begin
      goto(75 + i);
      lnk.rxrsp_lcrdv = 1'b1;
    end
    goto(90);
    lnk.rxrsp_lcrdv = 1'b0;
    goto(92);
    r = 92;
    lnk.RXLINKACTIVEREQ = 1'b1;
    for (int i = 0; i < 15; i++) cq.push_back(r + 3 + i);
    goto(r + 19);
    @(negedge clk);
    chk("react_out_cnt", dut.out_q, 15);
    chk("react_credits_left", cq.size(), 0);

    // Underflow: 16 flits against 15 credits
    for (int k = 0; k < 16; k++) begin
      goto(115 + k);
      lnk.RXRSPFLITV = 1'b1;
      lnk.RXRSPFLIT  = mk_flit(3, 32'hBEEF_0000 + 32'(k));
      fq.push_back('{data: mk_flit(3, 32'hBEEF_0000 + 32'(k)), cyc: 116 + k});
      if (k == 15) begin
        @(negedge clk);
        chk("pre_uflow_out_cnt", dut.out_q, 0);
        chk("pre_uflow_err", lnk.rxrsp_crd_err, 0);
      end
    end
    goto(131);
    lnk.RXRSPFLITV = 1'b0;
    lnk.RXRSPFLIT  = '0;
    @(negedge clk);
    chk("uflow_err", lnk.rxrsp_crd_err, 1);
    chk("uflow_out_cnt", dut.out_q, 0);

    goto(133);
    rst = 1'b1;
    lnk.RXLINKACTIVEREQ = 1'b0;
    goto(134);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_err", lnk.rxrsp_crd_err, 0);

    // Flit in STOP: dropped and flagged
    goto(136);
    lnk.RXRSPFLITV = 1'b1;
    lnk.RXRSPFLIT  = mk_flit(4, 32'hDEAD);
    goto(137);
    lnk.RXRSPFLITV = 1'b0;
    lnk.RXRSPFLIT  = '0;
    @(negedge clk);
    chk("stop_flit_err", lnk.rxrsp_crd_err, 1);
    chk("stop_flit_fwd", lnk.rxrspflitv, 0);

    // pend_cnt overflow on the 16th credit
    goto(139);
    rst = 1'b1;
    goto(140);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      goto(141 + i);
      lnk.rxrsp_lcrdv = 1'b1;
      if (i == 15) begin
        @(negedge clk);
        chk("pend_full_no_err", lnk.rxrsp_crd_err, 0);
      end
    end
    goto(157);
    lnk.rxrsp_lcrdv = 1'b0;
    @(negedge clk);
    chk("oflow_err", lnk.rxrsp_crd_err, 1);
    chk("oflow_pend_sat", dut.pend_q, 15);

    // Mid-stream reset with out_cnt = 7
    goto(159);
    rst = 1'b1;
    goto(160);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      goto(161 + i);
      lnk.rxrsp_lcrdv = 1'b1;
    end
    goto(168);
    lnk.rxrsp_lcrdv = 1'b0;
    lnk.RXLINKACTIVEREQ = 1'b1;
    for (int i = 0; i < 7; i++) cq.push_back(171 + i);
    goto(180);
    @(negedge clk);
    chk("mid_out_cnt", dut.out_q, 7);
    goto(181);
    rst = 1'b1;
    lnk.RXLINKACTIVEREQ = 1'b0;
    lnk.RXRSPFLITV      = 1'b1;
    lnk.RXRSPFLIT       = mk_flit(6, 32'h7777);
    lnk.RXRSPFLITPEND   = 1'b1;
    lnk.rxrsp_lcrdv     = 1'b1;
    goto(182);
    rst = 1'b0;
    lnk.RXRSPFLITV    = 1'b0;
    lnk.RXRSPFLIT     = '0;
    lnk.RXRSPFLITPEND = 1'b0;
    lnk.rxrsp_lcrdv   = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_cnt", dut.out_q, 0);
    chk("mid_rst_pend_cnt", dut.pend_q, 0);
    chk("mid_rst_ack", lnk.RXLINKACTIVEACK, 0);
    chk("mid_rst_flitv", lnk.rxrspflitv, 0);
    chk("mid_rst_flit", lnk.rxrspflit, 0);
    chk("mid_rst_flitpend", lnk.rxrspflitpend, 0);
    chk("mid_rst_lcrdv", lnk.RXRSPLCRDV, 0);

    goto(186);
    @(negedge clk);
    chk("flits_outstanding", fq.size(), 0);
    chk("credits_outstanding", cq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
